// File: rtl/cgra_mem_pkg.sv
// Shared CGRA memory-side constants and flattened-bus index helpers.
package cgra_mem_pkg;

   localparam int PE_NUM       = 16;
   localparam int PE_PTR       = 4;
   localparam int MEM_BANK_NUM = 16;

   // Bank-address field of a 36-bit PE request FIFO entry
   localparam int ENTRY_W  = 36;
   localparam int BANK_LSB = 32;
   localparam int BANK_MSB = 35;

   function automatic int req_bit(input int p, input int b);
      return p * MEM_BANK_NUM + b;
   endfunction

   function automatic int idx_lsb(input int b);
      return b * PE_PTR;
   endfunction

endpackage

// File: rtl/bank_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first eligible PE at or after ptr.
module rr_pick
   import cgra_mem_pkg::*;
(
   input  logic [PE_NUM-1:0] elig,
   input  logic [PE_PTR-1:0] ptr,
   output logic              found,
   output logic [PE_PTR-1:0] win_idx
);

   logic [PE_NUM-1:0] w_rot;

   // Rotate so the pointer position lands on bit 0
   always_comb begin
      w_rot = PE_NUM'({elig, elig} >> ptr);
   end

   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      for (int k = PE_NUM - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            found   = 1'b1;
            win_idx = ptr + PE_PTR'(k);
         end
      end
   end

endmodule

// File: rtl/bank_rr_arbiter.sv
// Per-bank round-robin arbiter between PE request FIFOs and memory banks.
module bank_rr_arbiter
   import cgra_mem_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [PE_NUM*MEM_BANK_NUM-1:0] req_pea_to_bank,
   input  logic [MEM_BANK_NUM-1:0]        bank_ready,
   output logic [PE_NUM*MEM_BANK_NUM-1:0] gnt_bank_to_pea,
   output logic [MEM_BANK_NUM-1:0]        bank_gnt_vld,
   output logic [MEM_BANK_NUM*PE_PTR-1:0] bank_gnt_idx,
   output logic [MEM_BANK_NUM-1:0]        bank_conflict,
   output logic [PE_NUM-1:0]              req_err
);

   logic [PE_NUM*MEM_BANK_NUM-1:0] r_gnt;
   logic [MEM_BANK_NUM-1:0]        r_vld;
   logic [MEM_BANK_NUM*PE_PTR-1:0] r_idx;
   logic [MEM_BANK_NUM-1:0]        r_conflict;
   logic [PE_NUM-1:0]              r_req_err;
   logic [PE_PTR-1:0]              r_ptr [MEM_BANK_NUM];

   logic [PE_NUM-1:0]              w_busy;
   logic [PE_NUM-1:0]              w_elig [MEM_BANK_NUM];
   logic [MEM_BANK_NUM-1:0]        w_found;
   logic [PE_PTR-1:0]              w_win [MEM_BANK_NUM];

   logic [PE_NUM*MEM_BANK_NUM-1:0] w_nxt_gnt;
   logic [MEM_BANK_NUM-1:0]        w_nxt_vld;
   logic [MEM_BANK_NUM*PE_PTR-1:0] w_nxt_idx;
   logic [MEM_BANK_NUM-1:0]        w_nxt_conflict;
   logic [PE_NUM-1:0]              w_nxt_err;
   logic [MEM_BANK_NUM-1:0]        w_raw;

   // A PE being popped this cycle still shows that entry; keep it out
   always_comb begin
      for (int p = 0; p < PE_NUM; p++) begin
         w_busy[p] = |r_gnt[req_bit(p, 0) +: MEM_BANK_NUM];
      end
      for (int b = 0; b < MEM_BANK_NUM; b++) begin
         for (int p = 0; p < PE_NUM; p++) begin
            w_elig[b][p] = req_pea_to_bank[req_bit(p, b)] & ~w_busy[p];
         end
      end
   end

   for (genvar gb = 0; gb < MEM_BANK_NUM; gb++) begin : g_bank
      rr_pick u_pick (
         .elig    (w_elig[gb]),
         .ptr     (r_ptr[gb]),
         .found   (w_found[gb]),
         .win_idx (w_win[gb])
      );
   end

   always_comb begin
      w_nxt_gnt      = '0;
      w_nxt_vld      = '0;
      w_nxt_idx      = '0;
      w_nxt_conflict = '0;
      w_nxt_err      = '0;
      w_raw          = '0;
      for (int b = 0; b < MEM_BANK_NUM; b++) begin
         w_nxt_conflict[b] = |(w_elig[b] & (w_elig[b] - PE_NUM'(1)));
         if (w_found[b] && bank_ready[b]) begin
            w_nxt_vld[b] = 1'b1;
            w_nxt_idx[idx_lsb(b) +: PE_PTR] = w_win[b];
            w_nxt_gnt[req_bit(int'(w_win[b]), b)] = 1'b1;
         end
      end
      for (int p = 0; p < PE_NUM; p++) begin
         w_raw        = req_pea_to_bank[req_bit(p, 0) +: MEM_BANK_NUM];
         w_nxt_err[p] = |(w_raw & (w_raw - MEM_BANK_NUM'(1)));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_gnt      <= '0;
         r_vld      <= '0;
         r_idx      <= '0;
         r_conflict <= '0;
         r_req_err  <= '0;
         for (int b = 0; b < MEM_BANK_NUM; b++) begin
            r_ptr[b] <= '0;
         end
      end else begin
         r_gnt      <= w_nxt_gnt;
         r_vld      <= w_nxt_vld;
         r_idx      <= w_nxt_idx;
         r_conflict <= w_nxt_conflict;
         r_req_err  <= w_nxt_err;
         for (int b = 0; b < MEM_BANK_NUM; b++) begin
            if (w_found[b] && bank_ready[b]) begin
               r_ptr[b] <= w_win[b] + PE_PTR'(1);
            end
         end
      end
   end

   assign gnt_bank_to_pea = r_gnt;
   assign bank_gnt_vld    = r_vld;
   assign bank_gnt_idx    = r_idx;
   assign bank_conflict   = r_conflict;
   assign req_err         = r_req_err;

endmodule
